// File: rtl/bubble_sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_sort_pkg
//  Description : Shared types and helpers for the bubble-sort engine.
//                - state_t : controller state encoding (LOAD / SORT / UNLOAD)
//                - idx_w() : width of the j/p/n counters, one bit wider than
//                            needed to address DEPTH so they never wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
package bubble_sort_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SORT   = 2'd1,
        S_UNLOAD = 2'd2
    } state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_sort_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_sort_ctrl
//  Description : Sequencer for the bubble-sort engine. Owns the state
//                register, the load/unload counter n, the pass counter p,
//                the compare index j, the per-pass swap flag, the latched
//                sort order and the pass count reported to the outside.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                in_valid, out_ready   - upstream / downstream handshakes
//                descend               - requested order, sampled on last load
//                swap_req              - datapath says pair (j-1, j) is out of order
//                in_ready, busy,
//                out_valid, out_last   - status, decoded from registers only
//                ld, swap_en, shift_out, sel_j, desc - array controls
//                passes                - passes used by the most recent sort
//  Revision    : 1.0 - initial release
// ============================================================================
module bubble_sort_ctrl
    import bubble_sort_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH),
    parameter int IW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          out_ready,
    input  logic          descend,
    input  logic          swap_req,
    output logic          in_ready,
    output logic          busy,
    output logic          out_valid,
    output logic          out_last,
    output logic          ld,
    output logic          swap_en,
    output logic          shift_out,
    output logic [IW-1:0] sel_j,
    output logic          desc,
    output logic [PW-1:0] passes
);

    localparam logic [IW-1:0] c_last  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] c_p_max = IW'(DEPTH - 2);
    localparam logic [IW-1:0] c_one   = IW'(1);

    state_t        r_state;
    logic [IW-1:0] r_n;
    logic [IW-1:0] r_p;
    logic [IW-1:0] r_j;
    logic          r_swapped;
    logic          r_desc;
    logic [PW-1:0] r_passes;

    logic          w_swapped_now;

    // Status outputs depend only on registers: no input-to-output path.
    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state == S_SORT);
    assign out_valid = (r_state == S_UNLOAD);
    assign out_last  = (r_state == S_UNLOAD) && (r_n == c_last);

    assign ld        = in_ready && in_valid;
    assign swap_en   = busy && swap_req;
    assign shift_out = out_valid && out_ready;
    assign sel_j     = r_j;
    assign desc      = r_desc;
    assign passes    = r_passes;

    // Swap flag including the compare happening in the current cycle.
    assign w_swapped_now = r_swapped || swap_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_LOAD;
            r_n       <= '0;
            r_p       <= '0;
            r_j       <= '0;
            r_swapped <= 1'b0;
            r_desc    <= 1'b0;
            r_passes  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_n == c_last) begin
                            r_n       <= '0;
                            r_desc    <= descend;
                            r_p       <= '0;
                            r_j       <= c_last;
                            r_swapped <= 1'b0;
                            r_state   <= S_SORT;
                        end else begin
                            r_n <= r_n + c_one;
                        end
                    end
                end

                S_SORT: begin
                    if (r_j > r_p + c_one) begin
                        r_j       <= r_j - c_one;
                        r_swapped <= w_swapped_now;
                    end else begin
                        // End of pass: the pair (p, p+1) was just compared.
                        r_passes <= PW'(r_p + c_one);
                        if (!w_swapped_now || (r_p == c_p_max)) begin
                            r_n     <= '0;
                            r_state <= S_UNLOAD;
                        end else begin
                            r_p       <= r_p + c_one;
                            r_j       <= c_last;
                            r_swapped <= 1'b0;
                        end
                    end
                end

                S_UNLOAD: begin
                    if (out_ready) begin
                        if (r_n == c_last) begin
                            r_n     <= '0;
                            r_state <= S_LOAD;
                        end else begin
                            r_n <= r_n + c_one;
                        end
                    end
                end

                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bubble_sort_engine.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_sort_engine
//  Description : In-place bubble sort of DEPTH words of WIDTH bits, one
//                compare-and-swap per clock, ascending or descending, with
//                early exit on a swap-free pass. Words enter and leave over
//                valid/ready ports; results stream out from A[0].
//  Ports       : clk, rst_n                    - clock, async active-low reset
//                in_valid/in_ready/in_data     - load port
//                descend                       - order, sampled on last load
//                out_valid/out_ready/out_data  - unload port
//                out_last                      - marks the DEPTH-th result
//                busy                          - sorting in progress
//                passes                        - passes used by last sort
//  Revision    : 1.0 - initial release
// ============================================================================
module bubble_sort_engine
    import bubble_sort_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             descend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [PW-1:0]    passes
);

    localparam int IW = idx_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_ld;
    logic             w_swap_en;
    logic             w_shift_out;
    logic [IW-1:0]    w_sel_j;
    logic             w_desc;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_swap_req;

    bubble_sort_ctrl #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .IW    (IW)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .descend   (descend),
        .swap_req  (w_swap_req),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_last  (out_last),
        .ld        (w_ld),
        .swap_en   (w_swap_en),
        .shift_out (w_shift_out),
        .sel_j     (w_sel_j),
        .desc      (w_desc),
        .passes    (passes)
    );

    // One pair mux selects (A[j-1], A[j]); a single comparator decides.
    always_comb begin
        w_lo = '0;
        w_hi = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (w_sel_j == IW'(k)) begin
                w_lo = r_mem[k-1];
                w_hi = r_mem[k];
            end
        end
    end

    // Strict compares keep equal words in place (stable, unsigned).
    assign w_swap_req = w_desc ? (w_lo < w_hi) : (w_lo > w_hi);

    assign out_data = r_mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_ld) begin
            // Shift towards the top; the first word ends in A[DEPTH-1].
            r_mem[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_mem[k] <= r_mem[k-1];
            end
        end else if (w_swap_en) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (w_sel_j == IW'(k)) begin
                    r_mem[k-1] <= w_hi;
                    r_mem[k]   <= w_lo;
                end
            end
        end else if (w_shift_out) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                r_mem[k] <= r_mem[k+1];
            end
            r_mem[DEPTH-1] <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bubble_sort_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bubble_sort_engine
//  Description : Self-checking bench for bubble_sort_engine (WIDTH=4,
//                DEPTH=8). Expected outputs come from queue sort()/rsort();
//                expected pass and compare counts from a plain array
//                bubble-sort model of the algorithm.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bubble_sort_engine;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int PW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             descend = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic [PW-1:0]    passes;

    int total = 0;
    int bad   = 0;

    // Results of the most recent batch
    int got[$];
    int last_pos[$];
    int busy_cyc;
    int passes_seen;
    int stall_err;
    int excl_err;
    int gap_err;
    int tmo;

    bubble_sort_engine #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .descend   (descend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .passes    (passes)
    );

    always #5 clk = ~clk;

    // Reference model of the algorithm on a plain array: returns the number
    // of passes and compares a bubble sort from the top index downwards
    // performs, stopping after a swap-free pass or after DEPTH-1 passes.
    function automatic void ref_model(input int vals[DEPTH], input bit desc,
                                      output int exp_passes, output int exp_cmp);
        int  a[DEPTH];
        int  t;
        bit  sw;
        for (int k = 0; k < DEPTH; k++) a[k] = vals[DEPTH-1-k];
        exp_passes = 0;
        exp_cmp    = 0;
        for (int p = 0; p < DEPTH - 1; p++) begin
            sw = 1'b0;
            for (int j = DEPTH - 1; j > p; j--) begin
                exp_cmp++;
                if (desc ? (a[j-1] < a[j]) : (a[j-1] > a[j])) begin
                    t = a[j-1]; a[j-1] = a[j]; a[j] = t; sw = 1'b1;
                end
            end
            exp_passes = p + 1;
            if (!sw) break;
        end
    endfunction

    function automatic bit excl_bad();
        return ($countones({in_ready, busy, out_valid}) != 1);
    endfunction

    // Drives one batch starting at a negedge; ends on the negedge after the
    // last unload handshake. Records outputs and protocol anomalies.
    task automatic run_batch(input int vals[DEPTH], input bit desc,
                             input bit rand_ready, input bit hold_valid);
        int n;
        int cyc;
        bit prev_stall;
        bit hs;
        logic [WIDTH-1:0] pd;
        logic pl;
        got.delete();
        last_pos.delete();
        busy_cyc = 0; passes_seen = -1;
        stall_err = 0; excl_err = 0; gap_err = 0; tmo = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(vals[i]);
            descend  = (i == DEPTH - 1) ? desc : ~desc;
            if (in_ready !== 1'b1) gap_err++;
            if (excl_bad()) excl_err++;
            @(posedge clk); @(negedge clk);
        end
        descend  = ~desc;
        in_valid = hold_valid;
        while (busy === 1'b1 && busy_cyc < 200) begin
            if (excl_bad()) excl_err++;
            in_data = WIDTH'($urandom);
            busy_cyc++;
            @(posedge clk); @(negedge clk);
        end
        n = 0; cyc = 0; prev_stall = 1'b0; pd = '0; pl = 1'b0;
        while (n < DEPTH && cyc < 500) begin
            cyc++;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (excl_bad()) excl_err++;
            if (prev_stall && (out_data !== pd || out_last !== pl)) stall_err++;
            if (out_valid === 1'b1) passes_seen = int'(passes);
            hs = (out_valid === 1'b1) && out_ready;
            if (hs && n == DEPTH - 1) in_valid = 1'b0;
            else if (hold_valid) begin
                in_valid = 1'b1;
                in_data  = WIDTH'($urandom);
            end
            pd = out_data; pl = out_last;
            prev_stall = (out_valid === 1'b1) && !out_ready;
            if (hs) begin
                got.push_back(int'(out_data));
                if (out_last === 1'b1) last_pos.push_back(n);
                n++;
            end else if (out_valid === 1'b1 && out_last === 1'b1 && n != DEPTH - 1) begin
                last_pos.push_back(100 + n);
            end
            @(posedge clk); @(negedge clk);
        end
        if (n < DEPTH) tmo = 1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (in_ready !== 1'b1) gap_err++;
    endtask

    task automatic test_reset();
        total++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, out_last, busy});
        end
        total++;
        if (passes !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset_data: passes=%0d out_data=%0d want 0/0", passes, out_data);
        end
    endtask

    task automatic test_mixed_ascend();
        int v[DEPTH];
        int q[$];
        v = '{3, 7, 1, 0, 15, 2, 2, 9};
        for (int i = 0; i < DEPTH; i++) q.push_back(v[i]);
        q.sort();
        run_batch(v, 1'b0, 1'b0, 1'b0);
        total++;
        if (tmo !== 0 || got.size() != DEPTH) begin
            bad++;
            $display("FAIL mixed_count: got %0d words want %0d", got.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                total++;
                if (got[i] != q[i]) begin
                    bad++;
                    $display("FAIL mixed_word%0d: got %0d want %0d", i, got[i], q[i]);
                end
            end
        end
        total++;
        if (last_pos.size() != 1 || last_pos[0] != DEPTH - 1) begin
            bad++;
            $display("FAIL mixed_last: out_last seen %0d times want once on word %0d",
                     last_pos.size(), DEPTH - 1);
        end
    endtask

    task automatic test_order_extremes(input bit reverse_load);
        int v[DEPTH];
        int ep, ec;
        for (int i = 0; i < DEPTH; i++) v[i] = reverse_load ? (15 - i) : i;
        ref_model(v, 1'b0, ep, ec);
        run_batch(v, 1'b0, 1'b0, 1'b0);
        total++;
        if (busy_cyc != ec) begin
            bad++;
            $display("FAIL busy_len(rev=%0d): got %0d want %0d", reverse_load, busy_cyc, ec);
        end
        total++;
        if (passes_seen != ep) begin
            bad++;
            $display("FAIL passes(rev=%0d): got %0d want %0d", reverse_load, passes_seen, ep);
        end
        total++;
        if (got.size() != DEPTH) begin
            bad++;
            $display("FAIL extreme_count(rev=%0d): got %0d want %0d", reverse_load, got.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                total++;
                if (got[i] != (reverse_load ? 8 + i : i)) begin
                    bad++;
                    $display("FAIL extreme_word%0d(rev=%0d): got %0d want %0d",
                             i, reverse_load, got[i], reverse_load ? 8 + i : i);
                end
            end
        end
    endtask

    task automatic test_descend();
        int v[DEPTH];
        int q[$];
        v = '{3, 7, 1, 0, 15, 2, 2, 9};
        for (int i = 0; i < DEPTH; i++) q.push_back(v[i]);
        q.rsort();
        run_batch(v, 1'b1, 1'b0, 1'b0);
        total++;
        if (got.size() != DEPTH) begin
            bad++;
            $display("FAIL desc_count: got %0d want %0d", got.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                total++;
                if (got[i] != q[i]) begin
                    bad++;
                    $display("FAIL desc_word%0d: got %0d want %0d", i, got[i], q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int v[DEPTH];
        int q[$];
        int ep, ec;
        bit d;
        for (int b = 0; b < 6; b++) begin
            q.delete();
            d = 1'($urandom_range(0, 1));
            for (int i = 0; i < DEPTH; i++) begin
                v[i] = int'($urandom_range(0, 15));
                q.push_back(v[i]);
            end
            if (d) q.rsort(); else q.sort();
            ref_model(v, d, ep, ec);
            run_batch(v, d, 1'b1, 1'b1);
            total++;
            if (stall_err != 0 || excl_err != 0 || gap_err != 0 || tmo != 0) begin
                bad++;
                $display("FAIL b2b_protocol%0d: stall=%0d excl=%0d gap=%0d tmo=%0d want all 0",
                         b, stall_err, excl_err, gap_err, tmo);
            end
            total++;
            if (busy_cyc != ec || passes_seen != ep) begin
                bad++;
                $display("FAIL b2b_timing%0d: busy=%0d passes=%0d want %0d/%0d",
                         b, busy_cyc, passes_seen, ec, ep);
            end
            total++;
            if (got.size() != DEPTH || got != q) begin
                bad++;
                $display("FAIL b2b_data%0d: got %p want %p", b, got, q);
            end
        end
    endtask

    task automatic test_reset_mid_sort();
        int v[DEPTH];
        int q[$];
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            descend  = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midsort_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            bad++;
            $display("FAIL async_reset: in_ready/busy/out_valid=%b want 100",
                     {in_ready, busy, out_valid});
        end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        v = '{5, 4, 3, 2, 1, 0, 7, 6};
        for (int i = 0; i < DEPTH; i++) q.push_back(v[i]);
        q.sort();
        run_batch(v, 1'b0, 1'b0, 1'b0);
        total++;
        if (got.size() != DEPTH || got != q) begin
            bad++;
            $display("FAIL post_reset_data: got %p want %p", got, q);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_mixed_ascend();
        test_order_extremes(1'b1);
        test_order_extremes(1'b0);
        test_descend();
        test_back_to_back();
        test_reset_mid_sort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
